// File: rtl/l2_mem_fill_resp.sv
// Builds the requester reply once a memory fill has completed, holds it until msg2 handshakes,
// then issues a single-cycle directory update that frees the message slot.
module l2_mem_fill_resp #(
  parameter logic [7:0] LOAD_REQ   = 8'h02,
  parameter logic [7:0] STORE_REQ  = 8'h03,
  parameter logic [7:0] LOAD_RESP  = 8'h12,
  parameter logic [7:0] STORE_RESP = 8'h13,
  parameter int         TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_done,
  input  logic [7:0]  cur_msg_type,
  input  logic [5:0]  cur_msg_source,
  input  logic [25:0] cur_msg_tag,
  input  logic [63:0] cache_data,
  input  logic [63:0] share_list_in,
  output logic        fill_ready,
  output logic        msg2_valid,
  input  logic        msg2_ready,
  output logic [7:0]  msg2_type,
  output logic [5:0]  msg2_dest,
  output logic [25:0] msg2_tag,
  output logic [63:0] msg2_data,
  output logic        upd_valid,
  output logic [1:0]  upd_state,
  output logic [5:0]  upd_owner,
  output logic [63:0] upd_share_list,
  output logic [1:0]  upd_msg_state,
  output logic        err_type,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] STALL_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] STALL_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, UPDATE} state_t;

  state_t        state;
  logic [CW-1:0] stall_cnt;
  logic          is_store;
  logic [63:0]   share_list_q;
  logic          type_known;
  logic [63:0]   src_onehot;

  assign type_known    = (cur_msg_type == LOAD_REQ) || (cur_msg_type == STORE_REQ);
  assign src_onehot    = 64'd1 << msg2_dest;
  assign upd_msg_state = 2'b00;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      stall_cnt      <= '0;
      is_store       <= 1'b0;
      share_list_q   <= '0;
      fill_ready     <= 1'b1;
      msg2_valid     <= 1'b0;
      msg2_type      <= '0;
      msg2_dest      <= '0;
      msg2_tag       <= '0;
      msg2_data      <= '0;
      upd_valid      <= 1'b0;
      upd_state      <= '0;
      upd_owner      <= '0;
      upd_share_list <= '0;
      err_type       <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fill_done) begin
            if (type_known) begin
              is_store     <= (cur_msg_type == STORE_REQ);
              share_list_q <= share_list_in;
              msg2_type    <= (cur_msg_type == STORE_REQ) ? STORE_RESP : LOAD_RESP;
              msg2_dest    <= cur_msg_source;
              msg2_tag     <= cur_msg_tag;
              msg2_data    <= cache_data;
              msg2_valid   <= 1'b1;
              fill_ready   <= 1'b0;
              state        <= SEND;
            end else begin
              err_type <= 1'b1;
            end
          end
        end
        SEND: begin
          if (fill_done) err_type <= 1'b1;
          if (msg2_ready) begin
            msg2_valid     <= 1'b0;
            stall_cnt      <= '0;
            upd_valid      <= 1'b1;
            upd_state      <= is_store ? 2'd2 : 2'd1;
            upd_owner      <= msg2_dest;
            // A store takes exclusive ownership, so every other sharer is dropped.
            upd_share_list <= is_store ? src_onehot : (share_list_q | src_onehot);
            state          <= UPDATE;
          end else if (stall_cnt != STALL_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == STALL_LAST) err_timeout <= 1'b1;
          end
        end
        UPDATE: begin
          if (fill_done) err_type <= 1'b1;
          upd_valid      <= 1'b0;
          upd_state      <= '0;
          upd_owner      <= '0;
          upd_share_list <= '0;
          fill_ready     <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
